pc_sequencer: RTL and testbench

- Owns the fetch PC and the decode/execute PC pipeline (dpc, epc) that feed the branch controller.
- Sequences normal fetch, load-use stalls, delay-slot-preserving redirects and debug manual addressing.
- Drives the stall and manual-addressing controls consumed by the branch controller.
- Sits between the instruction memory fetch port, the hazard unit and the execute-stage branch resolution.

---
 rtl/pc_sequencer.sv | 156 +++++++++++++++
 tb/tb_pc_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch PC and decode/execute PC pipeline sequencer: normal fetch, load-use stalls,
// delay-slot-preserving redirects and debug manual addressing.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned STALL_CYCLES = 1
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        w_hazard,
  input  logic        w_redirect,
  input  logic [31:0] w_redirect_pc_32,
  input  logic        w_imem_ready,
  input  logic        w_dbg_req,
  input  logic [31:0] w_dbg_addr_32,
  input  logic        w_dbg_step,
  output logic [31:0] w_pc_32,
  output logic [31:0] w_dpc_32,
  output logic [31:0] w_epc_32,
  output logic        w_ex_valid,
  output logic        w_fetch_valid,
  output logic        w_stall,
  output logic        w_manual_addressing,
  output logic        w_dbg_ack
);

  // state | meaning
  // BOOT  | one idle cycle after reset
  // RUN   | normal fetch
  // STALL | load-use hazard holds fetch/decode
  // HALT  | debug manual addressing, fetch off
  // STEP  | single debug fetch
  typedef enum logic [2:0] {S_BOOT, S_RUN, S_STALL, S_HALT, S_STEP} state_t;

  localparam logic [3:0] STALL_LOAD = 4'(STALL_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, dpc_q, dpc_d, epc_q, epc_d, pend_pc_q, pend_pc_d;
  logic        pend_q, pend_d, dvalid_q, dvalid_d, exv_q, exv_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        stall_q, manual_q, ack_q, fv_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    dpc_d     = dpc_q;
    epc_d     = epc_q;
    pend_pc_d = pend_pc_q;
    pend_d    = pend_q;
    dvalid_d  = dvalid_q;
    exv_d     = exv_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (w_hazard) begin
          state_d = S_STALL;
          cnt_d   = STALL_LOAD;
          epc_d   = '0;
          exv_d   = 1'b0;
          if (w_redirect) begin
            pend_d    = 1'b1;
            pend_pc_d = w_redirect_pc_32;
          end
        end else if (w_dbg_req) begin
          state_d = S_HALT;
          pend_d  = 1'b0;
          exv_d   = 1'b0;
        end else if (w_redirect || w_imem_ready) begin
          // ex_valid follows decode validity so reset garbage never reaches execute
          epc_d    = dpc_q;
          exv_d    = dvalid_q;
          dpc_d    = pc_q;
          dvalid_d = 1'b1;
          pend_d   = 1'b0;
          if (w_redirect)  pc_d = w_redirect_pc_32;
          else if (pend_q) pc_d = pend_pc_q;
          else             pc_d = pc_q + 32'd4;
        end
      end
      S_STALL: begin
        epc_d = '0;
        exv_d = 1'b0;
        if (w_redirect) begin
          pend_d    = 1'b1;
          pend_pc_d = w_redirect_pc_32;
        end
        if (cnt_q <= 4'd1) begin
          if (w_hazard) cnt_d = STALL_LOAD;
          else          state_d = S_RUN;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_HALT: begin
        exv_d = 1'b0;
        if (!w_dbg_req)      state_d = S_RUN;
        else if (w_dbg_step) state_d = S_STEP;
        else                 pc_d = w_dbg_addr_32;
      end
      S_STEP: begin
        if (w_imem_ready) begin
          epc_d    = dpc_q;
          exv_d    = dvalid_q;
          dpc_d    = pc_q;
          dvalid_d = 1'b1;
          pc_d     = pc_q + 32'd4;
          state_d  = w_dbg_req ? S_HALT : S_RUN;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // Mode outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_VECTOR;
      dpc_q     <= '0;
      epc_q     <= '0;
      pend_pc_q <= '0;
      pend_q    <= 1'b0;
      dvalid_q  <= 1'b0;
      exv_q     <= 1'b0;
      cnt_q     <= '0;
      stall_q   <= 1'b0;
      manual_q  <= 1'b0;
      ack_q     <= 1'b0;
      fv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      dpc_q     <= dpc_d;
      epc_q     <= epc_d;
      pend_pc_q <= pend_pc_d;
      pend_q    <= pend_d;
      dvalid_q  <= dvalid_d;
      exv_q     <= exv_d;
      cnt_q     <= cnt_d;
      stall_q   <= (state_d == S_STALL);
      manual_q  <= (state_d == S_HALT) || (state_d == S_STEP);
      ack_q     <= (state_d == S_HALT);
      fv_q      <= (state_d == S_RUN) || (state_d == S_STEP);
    end
  end

  assign w_pc_32             = pc_q;
  assign w_dpc_32            = dpc_q;
  assign w_epc_32            = epc_q;
  assign w_ex_valid          = exv_q;
  assign w_fetch_valid       = fv_q;
  assign w_stall             = stall_q;
  assign w_manual_addressing = manual_q;
  assign w_dbg_ack           = ack_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural pipeline model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'h100;
  localparam int          SC = 2;

  logic        w_clk = 1'b0;
  logic        w_rst = 1'b1;
  logic        w_hazard = 1'b0;
  logic        w_redirect = 1'b0;
  logic [31:0] w_redirect_pc_32 = '0;
  logic        w_imem_ready = 1'b1;
  logic        w_dbg_req = 1'b0;
  logic [31:0] w_dbg_addr_32 = '0;
  logic        w_dbg_step = 1'b0;
  logic [31:0] w_pc_32, w_dpc_32, w_epc_32;
  logic        w_ex_valid, w_fetch_valid, w_stall, w_manual_addressing, w_dbg_ack;

  int n_checks = 0;
  int n_pass   = 0;

  pc_sequencer #(.RESET_VECTOR(RV), .STALL_CYCLES(SC)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .w_hazard(w_hazard), .w_redirect(w_redirect),
    .w_redirect_pc_32(w_redirect_pc_32), .w_imem_ready(w_imem_ready),
    .w_dbg_req(w_dbg_req), .w_dbg_addr_32(w_dbg_addr_32), .w_dbg_step(w_dbg_step),
    .w_pc_32(w_pc_32), .w_dpc_32(w_dpc_32), .w_epc_32(w_epc_32),
    .w_ex_valid(w_ex_valid), .w_fetch_valid(w_fetch_valid), .w_stall(w_stall),
    .w_manual_addressing(w_manual_addressing), .w_dbg_ack(w_dbg_ack)
  );

  always #5 w_clk = ~w_clk;

  // Behavioural model: pipeline registers plus mode flags and a remaining-stall count.
  logic [31:0] m_pc = '0, m_dpc = '0, m_epc = '0, m_ptgt = '0;
  logic        m_dv = 1'b0, m_exv = 1'b0, m_pend = 1'b0;
  logic        m_boot = 1'b1, m_halt = 1'b0, m_stepping = 1'b0;
  int          m_left = 0;

  logic [100:0] dut_vec;
  assign dut_vec = {w_pc_32, w_dpc_32, w_epc_32, w_ex_valid, w_fetch_valid,
                    w_stall, w_manual_addressing, w_dbg_ack};

  function automatic logic [100:0] exp_vec();
    logic fv;
    fv = !m_boot && !m_halt && (m_left == 0);
    return {m_pc, m_dpc, m_epc, m_exv, fv, (m_left != 0), (m_halt || m_stepping), m_halt};
  endfunction

  task automatic m_advance(input logic [31:0] nxt);
    m_epc = m_dpc;
    m_exv = m_dv;
    m_dpc = m_pc;
    m_dv  = 1'b1;
    m_pc  = nxt;
  endtask

  task automatic model_step();
    if (w_rst) begin
      m_pc = RV; m_dpc = 0; m_epc = 0; m_dv = 0; m_exv = 0; m_pend = 0;
      m_boot = 1; m_halt = 0; m_stepping = 0; m_left = 0;
    end else if (m_boot) begin
      m_boot = 0;
    end else if (m_left > 0) begin
      m_epc = 0; m_exv = 0;
      if (w_redirect) begin m_pend = 1; m_ptgt = w_redirect_pc_32; end
      if (m_left == 1 && w_hazard) m_left = SC;
      else m_left = m_left - 1;
    end else if (m_halt) begin
      m_exv = 0;
      if (!w_dbg_req) m_halt = 0;
      else if (w_dbg_step) begin m_halt = 0; m_stepping = 1; end
      else m_pc = w_dbg_addr_32;
    end else if (m_stepping) begin
      if (w_imem_ready) begin
        m_advance(m_pc + 32'd4);
        m_stepping = 0;
        m_halt = w_dbg_req;
      end
    end else if (w_hazard) begin
      m_left = SC; m_epc = 0; m_exv = 0;
      if (w_redirect) begin m_pend = 1; m_ptgt = w_redirect_pc_32; end
    end else if (w_dbg_req) begin
      m_halt = 1; m_pend = 0; m_exv = 0;
    end else if (w_redirect || w_imem_ready) begin
      m_advance(w_redirect ? w_redirect_pc_32 : (m_pend ? m_ptgt : m_pc + 32'd4));
      m_pend = 0;
    end
  endtask

  task automatic tick();
    @(posedge w_clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    w_rst = 1; w_imem_ready = 1;
    tick();
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL reset_model got %h want %h", dut_vec, exp_vec()); else n_pass++;
    n_checks++; if ({w_pc_32, w_dpc_32, w_epc_32} !== {RV, 64'h0}) $display("FAIL reset_pcs got %h/%h/%h want 100/0/0", w_pc_32, w_dpc_32, w_epc_32); else n_pass++;
    n_checks++; if ({w_ex_valid, w_fetch_valid, w_stall, w_manual_addressing, w_dbg_ack} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {w_ex_valid, w_fetch_valid, w_stall, w_manual_addressing, w_dbg_ack}); else n_pass++;
    w_rst = 0;
    tick();
    n_checks++; if (w_fetch_valid !== 1'b1 || w_pc_32 !== RV) $display("FAIL boot_exit got fv=%b pc=%h want fv=1 pc=100", w_fetch_valid, w_pc_32); else n_pass++;
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_checks++; if (w_pc_32 !== RV + 32'(4 * i) || w_dpc_32 !== RV + 32'(4 * (i - 1)))
        $display("FAIL fetch_seq%0d got pc=%h dpc=%h want pc=%h dpc=%h", i, w_pc_32, w_dpc_32, RV + 32'(4 * i), RV + 32'(4 * (i - 1)));
      else n_pass++;
      n_checks++; if (w_ex_valid !== (i >= 2)) $display("FAIL ex_valid_start%0d got %b want %b", i, w_ex_valid, (i >= 2)); else n_pass++;
    end
  endtask

  task automatic test_redirect();
    w_redirect = 1; w_redirect_pc_32 = 32'h200;
    tick();
    w_redirect_pc_32 = 32'h400;
    tick();
    n_checks++; if ({w_pc_32, w_dpc_32, w_epc_32} !== {32'h400, 32'h200, 32'h10C})
      $display("FAIL redirect_delay_slot got %h/%h/%h want 400/200/10c", w_pc_32, w_dpc_32, w_epc_32);
    else n_pass++;
    n_checks++; if (w_stall !== 1'b0) $display("FAIL redirect_stall got %b want 0", w_stall); else n_pass++;
    w_imem_ready = 0; w_redirect_pc_32 = 32'h500;
    tick();
    n_checks++; if (w_pc_32 !== 32'h500 || w_dpc_32 !== 32'h400) $display("FAIL redirect_not_ready got pc=%h dpc=%h want 500/400", w_pc_32, w_dpc_32); else n_pass++;
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL redirect_model got %h want %h", dut_vec, exp_vec()); else n_pass++;
    w_imem_ready = 1; w_redirect = 0;
  endtask

  task automatic test_hazard_redirect();
    int n_st;
    w_redirect = 1; w_redirect_pc_32 = 32'h300;
    tick();
    w_hazard = 1; w_redirect_pc_32 = 32'h800;
    tick();
    w_hazard = 0; w_redirect = 0;
    n_st = 0;
    for (int k = 0; k < 20 && w_stall === 1'b1; k++) begin
      n_st++;
      n_checks++; if (w_pc_32 !== 32'h300 || w_epc_32 !== 32'h0 || w_ex_valid !== 1'b0)
        $display("FAIL stall_hold got pc=%h epc=%h exv=%b want 300/0/0", w_pc_32, w_epc_32, w_ex_valid);
      else n_pass++;
      tick();
    end
    n_checks++; if (n_st !== SC) $display("FAIL stall_len got %0d want %0d", n_st, SC); else n_pass++;
    n_checks++; if (w_pc_32 !== 32'h300) $display("FAIL stall_exit_pc got %h want 300", w_pc_32); else n_pass++;
    tick();
    n_checks++; if (w_pc_32 !== 32'h800) $display("FAIL pending_target got %h want 800", w_pc_32); else n_pass++;
    tick();
    n_checks++; if (w_pc_32 !== 32'h804) $display("FAIL pending_cleared got %h want 804", w_pc_32); else n_pass++;
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL hazard_model got %h want %h", dut_vec, exp_vec()); else n_pass++;
  endtask

  task automatic test_debug();
    w_dbg_req = 1; w_dbg_addr_32 = 32'h1000;
    tick();
    n_checks++; if ({w_dbg_ack, w_manual_addressing, w_fetch_valid} !== 3'b110 || w_pc_32 !== 32'h804)
      $display("FAIL halt_entry got ack/man/fv=%b pc=%h want 110 pc=804", {w_dbg_ack, w_manual_addressing, w_fetch_valid}, w_pc_32);
    else n_pass++;
    tick();
    n_checks++; if (w_pc_32 !== 32'h1000) $display("FAIL halt_load got %h want 1000", w_pc_32); else n_pass++;
    w_dbg_step = 1;
    tick();
    w_dbg_step = 0;
    n_checks++; if ({w_dbg_ack, w_manual_addressing, w_fetch_valid} !== 3'b011)
      $display("FAIL step_flags got %b want 011", {w_dbg_ack, w_manual_addressing, w_fetch_valid});
    else n_pass++;
    tick();
    n_checks++; if (w_pc_32 !== 32'h1004 || w_dpc_32 !== 32'h1000 || w_dbg_ack !== 1'b1 || w_fetch_valid !== 1'b0)
      $display("FAIL step_done got pc=%h dpc=%h ack=%b fv=%b want 1004/1000/1/0", w_pc_32, w_dpc_32, w_dbg_ack, w_fetch_valid);
    else n_pass++;
    w_dbg_req = 0;
    tick();
    n_checks++; if ({w_dbg_ack, w_manual_addressing, w_fetch_valid} !== 3'b001 || w_pc_32 !== 32'h1004)
      $display("FAIL debug_exit got %b pc=%h want 001 pc=1004", {w_dbg_ack, w_manual_addressing, w_fetch_valid}, w_pc_32);
    else n_pass++;
    tick();
    n_checks++; if (w_pc_32 !== 32'h1008) $display("FAIL resume_fetch got %h want 1008", w_pc_32); else n_pass++;
    n_checks++; if (dut_vec !== exp_vec()) $display("FAIL debug_model got %h want %h", dut_vec, exp_vec()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    w_hazard = 1; w_redirect = 1; w_redirect_pc_32 = 32'h900;
    tick();
    w_hazard = 0; w_redirect = 0;
    n_checks++; if (w_stall !== 1'b1) $display("FAIL mid_stall_entry got %b want 1", w_stall); else n_pass++;
    w_rst = 1;
    tick();
    n_checks++; if (dut_vec !== {RV, 64'h0, 5'b0}) $display("FAIL mid_stall_reset got %h want %h", dut_vec, {RV, 64'h0, 5'b0}); else n_pass++;
    w_rst = 0;
    tick();
    tick();
    n_checks++; if (w_pc_32 !== RV + 32'h4) $display("FAIL pending_discard got %h want 104", w_pc_32); else n_pass++;
    w_dbg_req = 1;
    tick();
    tick();
    n_checks++; if (w_dbg_ack !== 1'b1 || w_pc_32 !== 32'h1000) $display("FAIL halt_before_reset got ack=%b pc=%h want 1/1000", w_dbg_ack, w_pc_32); else n_pass++;
    w_rst = 1; w_dbg_req = 0;
    tick();
    n_checks++; if (dut_vec !== {RV, 64'h0, 5'b0}) $display("FAIL mid_halt_reset got %h want %h", dut_vec, {RV, 64'h0, 5'b0}); else n_pass++;
    w_rst = 0;
    tick();
  endtask

  task automatic test_wrap_and_ready();
    w_redirect = 1; w_redirect_pc_32 = 32'hFFFF_FFFC;
    tick();
    w_redirect = 0;
    tick();
    n_checks++; if (w_pc_32 !== 32'h0 || w_dpc_32 !== 32'hFFFF_FFFC) $display("FAIL pc_wrap got pc=%h dpc=%h want 0/fffffffc", w_pc_32, w_dpc_32); else n_pass++;
    w_imem_ready = 0;
    repeat (3) begin
      tick();
      n_checks++; if (w_pc_32 !== 32'h0 || w_dpc_32 !== 32'hFFFF_FFFC || w_epc_32 !== m_epc)
        $display("FAIL not_ready_hold got %h/%h/%h want 0/fffffffc/%h", w_pc_32, w_dpc_32, w_epc_32, m_epc);
      else n_pass++;
    end
    w_imem_ready = 1;
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int c = 0; c < 3000; c++) begin
      w_rst        = ($urandom_range(0, 199) == 0);
      w_hazard     = ($urandom_range(0, 99) < 15);
      w_redirect   = ($urandom_range(0, 99) < 15);
      r = $urandom();
      w_redirect_pc_32 = r & 32'hFFFF_FFFC;
      w_imem_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 4) w_dbg_req = ~w_dbg_req;
      r = $urandom();
      w_dbg_addr_32 = r & 32'hFFFF_FFFC;
      w_dbg_step   = ($urandom_range(0, 3) == 0);
      tick();
      n_checks++; if (dut_vec !== exp_vec()) $display("FAIL random_cycle%0d got %h want %h", c, dut_vec, exp_vec()); else n_pass++;
    end
    w_rst = 0; w_hazard = 0; w_redirect = 0; w_dbg_req = 0; w_dbg_step = 0; w_imem_ready = 1;
  endtask

  initial begin
    test_reset();
    test_redirect();
    test_hazard_redirect();
    test_debug();
    test_reset_mid();
    test_wrap_and_ready();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
